seq_adder_display: RTL and testbench

// - Registered, parametrised adder/accumulator driving a time-multiplexed multi-digit seven-segment display.
// - Successor to the 4-bit combinational adder + single-digit decoder path.
// - Adds:
//   - WIDTH-bit operands.
//   - Accumulate mode.
//   - start/valid handshake.
//   - Sticky overflow.
//   - Digit scanning for the board's common-anode display.

---
 rtl/seq_adder_display_pkg.sv | 16 +
 rtl/seq_adder_display_if.sv | 31 +++
 rtl/seq_adder_display_seg_hex_glyph.sv | 35 +++
 rtl/seq_adder_display.sv | 107 ++++++++++
 tb/tb_seq_adder_display.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_adder_display_pkg.sv
// Shared types and constants for the sequential adder / display block.
package seq_adder_display_pkg;

  // Operation select carried on the mode input.
  typedef enum logic {
    MODE_ADD = 1'b0,  // a + b + cin
    MODE_ACC = 1'b1   // sum_q + a + cin
  } op_mode_e;

  // Segment bus width: {g,f,e,d,c,b,a}.
  localparam int SEG_W = 7;

  // Pattern shown by every digit out of reset (a "0", active-low).
  localparam logic [SEG_W-1:0] SEG_RESET = 7'b1000000;

endpackage

// File: rtl/seq_adder_display_if.sv
// Operand / result bus between the requester and the adder core.
//
// Handshake: start is a single-cycle request with no backpressure; the
// operands a, b, cin and mode are sampled on the same rising edge that sees
// start=1. valid pulses high for exactly one cycle, the cycle in which sum_q,
// cout_q and ovf show the new result. clr is a synchronous clear that wins
// over a coincident start (that start is dropped and no valid is produced).
interface seq_adder_display_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             mode;
  logic             start;
  logic             clr;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf;
  logic             valid;

  modport master (
    output a, b, cin, mode, start, clr,
    input  sum_q, cout_q, ovf, valid
  );

  modport slave (
    input  a, b, cin, mode, start, clr,
    output sum_q, cout_q, ovf, valid
  );
endinterface

// File: rtl/seq_adder_display_seg_hex_glyph.sv
// Hex nibble to active-low seven-segment glyph, purely combinational.
// Glyphs 0-9, A, lowercase b, C, lowercase d, E, F.
module seg_hex_glyph
  import seq_adder_display_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);

  // Bit order {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [SEG_W-1:0] GLYPH [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  // Table lookup of the glyph for the selected nibble.
  always_comb begin
    seg = GLYPH[nibble];
  end

endmodule

// File: rtl/seq_adder_display.sv
// Registered adder/accumulator with sticky overflow, driving a
// time-multiplexed common-anode hex display (one digit per result nibble).
module seq_adder_display
  import seq_adder_display_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seq_adder_display_if.slave      bus,
  output logic [SEG_W-1:0]        seg,
  output logic [WIDTH/4-1:0]      an,
  output logic                    dp
);

  localparam int DIGITS = WIDTH / 4;
  localparam int CW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] CNT_MAX  = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  // Result state
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             valid_r;

  // Adder datapath
  logic [WIDTH-1:0] opnd;
  logic [WIDTH:0]   add_full;

  // Display scan state
  logic [CW-1:0]    scan_cnt;
  logic [IW-1:0]    digit_idx;
  logic [3:0]       nibble;

  // Second operand is either b or the running result, then one WIDTH+1 add.
  always_comb begin
    opnd     = (op_mode_e'(bus.mode) == MODE_ACC) ? sum_r : bus.b;
    add_full = {1'b0, opnd} + {1'b0, bus.a} + {{WIDTH{1'b0}}, bus.cin};
  end

  // Result register: clr beats start; valid is high only on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      valid_r <= 1'b0;
    end else if (bus.clr) begin
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      valid_r <= 1'b0;
    end else if (bus.start) begin
      sum_r   <= add_full[WIDTH-1:0];
      cout_r  <= add_full[WIDTH];
      ovf_r   <= ovf_r | add_full[WIDTH];
      valid_r <= 1'b1;
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign bus.sum_q  = sum_r;
  assign bus.cout_q = cout_r;
  assign bus.ovf    = ovf_r;
  assign bus.valid  = valid_r;

  // Refresh timer: each digit owns SCAN_DIV cycles, then the next one lights.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == CNT_MAX) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
    end else begin
      scan_cnt  <= scan_cnt + 1'b1;
    end
  end

  // Nibble mux and anode decode; constant slices keep every select in range.
  always_comb begin
    nibble = 4'h0;
    an     = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_idx == IW'(i)) begin
        nibble = sum_r[4*i +: 4];
        an[i]  = 1'b0;
      end
    end
  end

  // Decimal point on the most significant digit flags a sticky overflow.
  always_comb begin
    dp = ~((digit_idx == LAST_IDX) & ovf_r);
  end

  seg_hex_glyph u_glyph (
    .nibble (nibble),
    .seg    (seg)
  );

endmodule

// File: tb/tb_seq_adder_display.sv
// Bench for seq_adder_display: table of add/accumulate vectors scored through
// an expected queue, plus hand-written reset, overflow display, clr priority
// and scan sequences on an 8-bit and a 16-bit instance.
module tb_seq_adder_display;

  localparam int SCAN = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset release; drives the independent scan-position model.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // ---------------- DUTs ----------------
  seq_adder_display_if #(.WIDTH(8))  bus8 ();
  seq_adder_display_if #(.WIDTH(16)) bus16 ();

  logic [6:0] seg8, seg16;
  logic [1:0] an8;
  logic [3:0] an16;
  logic       dp8, dp16;

  seq_adder_display #(.WIDTH(8), .SCAN_DIV(SCAN)) dut8 (
    .clk (clk), .rst_n (rst_n), .bus (bus8.slave),
    .seg (seg8), .an (an8), .dp (dp8)
  );

  seq_adder_display #(.WIDTH(16), .SCAN_DIV(SCAN)) dut16 (
    .clk (clk), .rst_n (rst_n), .bus (bus16.slave),
    .seg (seg16), .an (an16), .dp (dp16)
  );

  localparam logic [6:0] GLYPH_REF [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [9:0] exp_q [$];  // {sum[7:0], cout, ovf}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every valid pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    logic [9:0] e;
    #1;
    if (rst_n && bus8.valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(bus8.valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sum_q",  32'(bus8.sum_q),  32'(e[9:2]));
        chk("cout_q", 32'(bus8.cout_q), 32'(e[1]));
        chk("ovf",    32'(bus8.ovf),    32'(e[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic mode, input logic [9:0] exp);
    @(negedge clk);
    bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.mode = mode;
    bus8.clr = 1'b0; bus8.start = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  task automatic clr_cycle();
    @(negedge clk);
    bus8.start = 1'b0; bus8.clr = 1'b1;
    @(negedge clk);
    bus8.clr = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    chk("drain_outstanding", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       pre_clr;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       mode;
    logic [7:0] exp_sum;
    logic       exp_cout;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int idx8, idx16;
    logic [15:0] val16;

    vecs[0] = '{1'b1, 8'h3C, 8'h05, 1'b1, 1'b0, 8'h42, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 8'h80, 8'h00, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h80, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 8'h80, 8'h00, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 8'h0F, 8'hAA, 1'b1, 1'b1, 8'h56, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 8'hA7, 8'h00, 1'b0, 1'b0, 8'hA7, 1'b0, 1'b0};

    bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.mode = 1'b0;
    bus8.start = 1'b0; bus8.clr = 1'b0;
    bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.mode = 1'b0;
    bus16.start = 1'b0; bus16.clr = 1'b0;

    // Reset values while held in reset from time zero.
    @(negedge clk);
    chk("rst_sum", 32'(bus8.sum_q), 32'd0);
    chk("rst_an",  32'(an8), 32'b10);
    chk("rst_seg", 32'(seg8), 32'b1000000);
    chk("rst_dp",  32'(dp8), 32'd1);

    // Run mid-scan with a first add, then reset with a start in flight.
    @(negedge clk);
    rst_n = 1'b1;
    start_op(8'h3C, 8'h05, 1'b1, 1'b0, {8'h42, 1'b0, 1'b0});
    @(negedge clk);
    chk("add_valid_drop", 32'(bus8.valid), 32'd0);
    chk("add_hold_sum", 32'(bus8.sum_q), 32'h42);
    @(negedge clk);
    bus8.a = 8'h11; bus8.b = 8'h22; bus8.start = 1'b1;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst_sum",   32'(bus8.sum_q), 32'd0);
      chk("midrst_valid", 32'(bus8.valid), 32'd0);
      chk("midrst_an",    32'(an8), 32'b10);
      chk("midrst_seg",   32'(seg8), 32'b1000000);
      chk("midrst_dp",    32'(dp8), 32'd1);
    end
    bus8.start = 1'b0;
    rst_n = 1'b1;

    // Table: consecutive vectors issue back-to-back starts.
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].pre_clr) begin
        @(negedge clk);
        bus8.start = 1'b0; bus8.clr = 1'b1;
      end
      @(negedge clk);
      bus8.clr = 1'b0;
      bus8.a = vecs[i].a; bus8.b = vecs[i].b;
      bus8.cin = vecs[i].cin; bus8.mode = vecs[i].mode;
      bus8.start = 1'b1;
      exp_q.push_back({vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf});
    end
    @(negedge clk);
    bus8.start = 1'b0;
    wait_drain();

    // Overflow display: dp low only while the top digit is lit.
    clr_cycle();
    start_op(8'hFF, 8'h01, 1'b0, 1'b0, {8'h00, 1'b1, 1'b1});
    wait_drain();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      idx8 = (cyc / SCAN) % 2;
      chk("ovf_an", 32'(an8), (idx8 == 0) ? 32'b10 : 32'b01);
      chk("ovf_dp", 32'(dp8), (idx8 == 1) ? 32'd0 : 32'd1);
    end

    // clr wins over a coincident start.
    start_op(8'h12, 8'h34, 1'b0, 1'b0, {8'h46, 1'b0, 1'b1});
    wait_drain();
    @(negedge clk);
    bus8.a = 8'h01; bus8.b = 8'h01; bus8.start = 1'b1; bus8.clr = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0; bus8.clr = 1'b0;
    chk("clrpri_sum",   32'(bus8.sum_q), 32'd0);
    chk("clrpri_cout",  32'(bus8.cout_q), 32'd0);
    chk("clrpri_ovf",   32'(bus8.ovf), 32'd0);
    chk("clrpri_valid", 32'(bus8.valid), 32'd0);

    // Scan: 8-bit shows A7, 16-bit shows bD27.
    @(negedge clk);
    bus16.a = 16'hBD27; bus16.b = 16'h0000; bus16.start = 1'b1;
    @(negedge clk);
    bus16.start = 1'b0;
    start_op(8'hA7, 8'h00, 1'b0, 1'b0, {8'hA7, 1'b0, 1'b0});
    wait_drain();
    chk("w16_sum", 32'(bus16.sum_q), 32'hBD27);
    val16 = 16'hBD27;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      idx8  = (cyc / SCAN) % 2;
      idx16 = (cyc / SCAN) % 4;
      chk("scan_an8",  32'(an8), (idx8 == 0) ? 32'b10 : 32'b01);
      chk("scan_seg8", 32'(seg8), (idx8 == 0) ? 32'b1111000 : 32'b0001000);
      chk("scan_dp8",  32'(dp8), 32'd1);
      chk("scan_an16", 32'(an16), 32'(4'hF & ~(4'b0001 << idx16)));
      chk("scan_seg16", 32'(seg16), 32'(GLYPH_REF[val16[4*idx16 +: 4]]));
    end

    wait_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Hard stop if the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
